// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V control FSM: opcodes, states,
// and datapath mux select values.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    typedef enum logic [1:0] {
        RES_ALUOUT    = 2'b00,
        RES_DATA      = 2'b01,
        RES_ALURESULT = 2'b10
    } result_src_t;

    typedef enum logic [1:0] {
        SRCA_PC    = 2'b00,
        SRCA_OLDPC = 2'b01,
        SRCA_RS1   = 2'b10
    } alu_src_a_t;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'b00,
        SRCB_IMM  = 2'b01,
        SRCB_FOUR = 2'b10
    } alu_src_b_t;

    typedef enum logic [1:0] {
        ALU_ADD    = 2'b00,
        ALU_BRANCH = 2'b01,
        ALU_FUNCT  = 2'b10
    } alu_op_t;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Control-unit <-> datapath/memory bundle. The control unit is the master:
// it consumes the opcode and memory handshake and drives every enable/select.
interface multicycle_control_unit_if #(
    parameter int OPCODE_W = 7
);
    import riscv_ctrl_pkg::*;

    logic [OPCODE_W-1:0] Opcode;
    logic                mem_ready;

    logic        PCWrite;
    logic        Branch;
    logic        IRWrite;
    logic        AdrSrc;
    logic        MemRead;
    logic        MemWrite;
    logic        RegWrite;
    result_src_t ResultSrc;
    alu_src_a_t  ALUSrcA;
    alu_src_b_t  ALUSrcB;
    alu_op_t     ALUOp;
    logic        instr_done;
    logic        illegal_instr;
    logic        mem_fault;
    logic [3:0]  state_o;

    modport master (
        input  Opcode, mem_ready,
        output PCWrite, Branch, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ALUOp,
               instr_done, illegal_instr, mem_fault, state_o
    );

    modport slave (
        output Opcode, mem_ready,
        input  PCWrite, Branch, IRWrite, AdrSrc, MemRead, MemWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ALUOp,
               instr_done, illegal_instr, mem_fault, state_o
    );

endinterface

// File: rtl/mem_wait_timer.sv
// Clearable saturating counter of consecutive memory-wait cycles; at_limit
// flags that LIMIT wait cycles have already elapsed.
module mem_wait_timer #(
    parameter int  LIMIT = 1,
    localparam int W     = $clog2(LIMIT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic at_limit
);

    localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && cnt != LIMIT_V)
            cnt <= cnt + 1'b1;
    end

    assign at_limit = (cnt == LIMIT_V);

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore control FSM for the multi-cycle RISC-V datapath with a variable-latency
// unified memory, illegal-opcode detection and an optional memory-wait timeout.
module multicycle_control_unit
    import riscv_ctrl_pkg::*;
#(
    parameter int OPCODE_W     = 7,
    parameter bit ENABLE_ITYPE = 1'b1,
    parameter bit ENABLE_JAL   = 1'b1,
    parameter int MEM_TIMEOUT  = 0
) (
    input  logic clk,
    input  logic reset,
    multicycle_control_unit_if.master bus
);

    state_t state, state_next;

    logic [OPCODE_W-1:0] opc_raw;
    logic [6:0]          opcode;
    logic                ready;
    logic                waiting;
    logic                expired;

    logic        pc_write, branch, ir_write, adr_src, mem_read, mem_write, reg_write;
    logic        done, illegal, fault;
    result_src_t res_src;
    alu_src_a_t  src_a;
    alu_src_b_t  src_b;
    alu_op_t     alu_op;

    assign opc_raw = bus.Opcode;
    assign opcode  = opc_raw[6:0];
    assign ready   = bus.mem_ready;

    // A wait cycle is any memory-facing state where the access has not completed.
    assign waiting = (state == S_FETCH || state == S_MEMREAD || state == S_MEMWRITE) && !ready;

    generate
        if (MEM_TIMEOUT > 0) begin : g_timer
            logic at_limit;
            logic timer_clr;

            assign timer_clr = !waiting || expired;

            mem_wait_timer #(.LIMIT(MEM_TIMEOUT)) u_timer (
                .clk      (clk),
                .rst      (reset),
                .clr      (timer_clr),
                .inc      (waiting),
                .at_limit (at_limit)
            );

            assign expired = at_limit && waiting;
        end else begin : g_no_timer
            assign expired = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_FETCH;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        pc_write   = 1'b0;
        branch     = 1'b0;
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        done       = 1'b0;
        illegal    = 1'b0;
        fault      = 1'b0;
        res_src    = RES_ALUOUT;
        src_a      = SRCA_PC;
        src_b      = SRCB_RS2;
        alu_op     = ALU_ADD;

        case (state)
            S_FETCH: begin
                mem_read = 1'b1;
                src_b    = SRCB_FOUR;
                res_src  = RES_ALURESULT;
                if (ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target is precomputed here from OldPC + Imm.
                src_a = SRCA_OLDPC;
                src_b = SRCB_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_RTYPE:          state_next = S_EXECR;
                    OP_BRANCH:         state_next = S_BEQ;
                    OP_ITYPE: begin
                        if (ENABLE_ITYPE) state_next = S_EXECI;
                        else begin
                            illegal    = 1'b1;
                            state_next = S_FETCH;
                        end
                    end
                    OP_JAL: begin
                        if (ENABLE_JAL) state_next = S_JAL;
                        else begin
                            illegal    = 1'b1;
                            state_next = S_FETCH;
                        end
                    end
                    default: begin
                        illegal    = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                src_a      = SRCA_RS1;
                src_b      = SRCB_IMM;
                state_next = (opcode == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                adr_src  = 1'b1;
                mem_read = 1'b1;
                if (ready) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                res_src    = RES_DATA;
                reg_write  = 1'b1;
                done       = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
                if (ready) begin
                    done       = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_EXECR: begin
                src_a      = SRCA_RS1;
                src_b      = SRCB_RS2;
                alu_op     = ALU_FUNCT;
                state_next = S_ALUWB;
            end
            S_EXECI: begin
                src_a      = SRCA_RS1;
                src_b      = SRCB_IMM;
                alu_op     = ALU_FUNCT;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                done       = 1'b1;
                state_next = S_FETCH;
            end
            S_BEQ: begin
                src_a      = SRCA_RS1;
                src_b      = SRCB_RS2;
                alu_op     = ALU_BRANCH;
                branch     = 1'b1;
                done       = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL: begin
                // ALUWB afterwards writes rd with OldPC + 4.
                src_a      = SRCA_OLDPC;
                src_b      = SRCB_FOUR;
                pc_write   = 1'b1;
                state_next = S_ALUWB;
            end
            default: state_next = S_FETCH;
        endcase

        // Timed-out access: drop the request, flag it and restart at FETCH.
        if (expired) begin
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            done       = 1'b0;
            fault      = 1'b1;
            state_next = S_FETCH;
        end

        // State is already FETCH during reset, so only the strobes need masking.
        if (reset) begin
            pc_write  = 1'b0;
            branch    = 1'b0;
            ir_write  = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            reg_write = 1'b0;
            done      = 1'b0;
            illegal   = 1'b0;
            fault     = 1'b0;
        end
    end

    assign bus.PCWrite       = pc_write;
    assign bus.Branch        = branch;
    assign bus.IRWrite       = ir_write;
    assign bus.AdrSrc        = adr_src;
    assign bus.MemRead       = mem_read;
    assign bus.MemWrite      = mem_write;
    assign bus.RegWrite      = reg_write;
    assign bus.ResultSrc     = res_src;
    assign bus.ALUSrcA       = src_a;
    assign bus.ALUSrcB       = src_b;
    assign bus.ALUOp         = alu_op;
    assign bus.instr_done    = done;
    assign bus.illegal_instr = illegal;
    assign bus.mem_fault     = fault;
    assign bus.state_o       = state;

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Moore-style control FSM for the multi-cycle RISC-V datapath. It replaces the single-cycle opcode decoder.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Handshakes with a variable-latency unified instruction/data memory.
- Adds I-type ALU, JAL, illegal-opcode detection and a parametrised memory-wait timeout.
- Sits between the instruction register opcode field and the datapath mux/enable lines.

Parameters:
OPCODE_W, 7, opcode field width.
ENABLE_ITYPE, 1, decode opcode 0010011 (I-type ALU); when 0 it is treated as illegal.
ENABLE_JAL, 1, decode opcode 1101111 (JAL); when 0 it is treated as illegal.
MEM_TIMEOUT, 0, maximum cycles to wait for mem_ready in a memory state. 0 disables the timeout.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
Opcode  input  OPCODE_W  instr[6:0] taken from the instruction register
mem_ready  input  1  memory completes the current read/write this cycle
PCWrite  output  1  PC register enable (unconditional)
Branch  output  1  PC enable qualified by ALU zero, driven to external logic
IRWrite  output  1  instruction register enable
AdrSrc  output  1  memory address select: 0=PC, 1=Result
MemRead  output  1  memory read request
MemWrite  output  1  memory write request
RegWrite  output  1  register file write enable
ResultSrc  output  2  result select: 00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA  output  2  ALU A select: 00=PC, 01=OldPC, 10=rs1
ALUSrcB  output  2  ALU B select: 00=rs2, 01=Imm, 10=const 4
ALUOp  output  2  ALU op class: 00=add, 01=branch compare, 10=funct decode
instr_done  output  1  asserted in the final cycle of each completed instruction
illegal_instr  output  1  one-cycle pulse in DECODE on an unsupported opcode
mem_fault  output  1  one-cycle pulse when the memory-wait timeout expires
state_o  output  4  current state encoding, for debug

Behaviour:
- Reset (asynchronous, active-high): state=FETCH and the wait counter is cleared.
  - While reset is high, PCWrite, IRWrite, MemRead, MemWrite, RegWrite, Branch, instr_done, illegal_instr and mem_fault are forced to 0.
  - While reset is high, the mux selects show their FETCH values.
  - Reset mid-instruction aborts the instruction with no further strobes.
- All outputs decode from the registered state plus mem_ready. Any output not listed for a state is 0.
- FETCH: AdrSrc=0, MemRead=1, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite and PCWrite are asserted only in a cycle with mem_ready=1; the FSM then moves to DECODE.
  - Otherwise the FSM stays in FETCH.
- DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (precompute branch target). Next state by Opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECR
  - 0010011 -> EXECI
  - 1100011 -> BEQ
  - 1101111 -> JAL
  - anything else -> FETCH, with illegal_instr=1 for this cycle.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next state is MEMREAD for a load, MEMWRITE for a store. Opcode is stable from the IR.
- MEMREAD: AdrSrc=1, ResultSrc=00, MemRead=1. Moves to MEMWB on mem_ready.
- MEMWB: ResultSrc=01, RegWrite=1, instr_done=1. Next state FETCH.
- MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1. On mem_ready: instr_done=1 and next state FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next state ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next state ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, instr_done=1. Next state FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1, instr_done=1. Next state FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1. Next state ALUWB, which writes rd=PC+4.
- Minimum cycle counts with mem_ready held at 1: R/I-type 4, load 5, store 4, BEQ 3, JAL 4.
- Wait counter (only when MEM_TIMEOUT>0):
  - Counts consecutive cycles in FETCH, MEMREAD or MEMWRITE with mem_ready=0.
  - Cleared on mem_ready=1 or on any state change.
  - When it reaches MEM_TIMEOUT and mem_ready is still 0: mem_fault=1 for that cycle, next state FETCH, no enables asserted, counter cleared.
  - mem_ready=1 in the same cycle as expiry means success; no fault.
  - Counter width is clog2(MEM_TIMEOUT+1) and it saturates; it never wraps.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - opcode constants (LOAD, STORE, RTYPE, ITYPE, BRANCH, JAL)
  - state encodings (FETCH=0 … JAL=10)
  - ResultSrc, ALUSrcA, ALUSrcB and ALUOp encodings.
- One sub-module, mem_wait_timer, holds the clearable saturating counter with an expire output. It is generated only when MEM_TIMEOUT>0.

Test Plan:
- Hold reset high mid-MEMREAD -> state_o=FETCH immediately, all strobes 0; after release, MemRead=1 and AdrSrc=0.
- mem_ready=1, Opcode=0110011 -> states FETCH, DECODE, EXECR, ALUWB; RegWrite=1 only in cycle 4, where instr_done=1.
- Opcode=0000011, mem_ready low for 2 cycles in MEMREAD -> MemRead held for 3 cycles; MEMWB has ResultSrc=01 and RegWrite=1; 7 cycles total.
- Opcode=0100011 -> MemWrite=1 and AdrSrc=1 in MEMWRITE; RegWrite never 1.
- Opcode=1100011 -> BEQ with Branch=1, ALUOp=01, PCWrite=0.
- Opcode=1101111 -> JAL with PCWrite=1, then ALUWB with RegWrite=1.
- Opcode=1111111 -> illegal_instr pulse in DECODE, then back to FETCH.
- MEM_TIMEOUT=3, mem_ready stuck at 0 in FETCH -> mem_fault pulses on the 4th cycle, IRWrite never 1, FSM restarts FETCH.
